rca_sum_arbiter: RTL and testbench
==================================

Name: rca_sum_arbiter

Overview:
Shares one 3-operand 8-bit ripple-carry summation datapath (a+b+c -> 11-bit result) between NREQ independent requesters. Each requester has a valid/ready handshake. A round-robin arbiter selects one request per cycle and feeds the shared adder. The result is held in a single output register with a requester tag until downstream accepts it. Sits between operand producers and the result consumer in the summation subsystem.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width; result width is W+3
IDW, 2, tag width, equal to clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester operand-triple valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*W  operand a, requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand b, same packing
req_c  in  NREQ*W  operand c, same packing
out_valid  out  1  result register holds a valid result
out_ready  in  1  downstream accepts the result
out_sum  out  W+3  a+b+c of the granted request, zero-extended
out_id  out  IDW  index of the requester that produced out_sum
op_count  out  16  number of results accepted downstream, wraps modulo 2^16

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_sum=0, out_id=0, op_count=0, RR pointer=0, req_ready=0. All other inputs are ignored while in reset.
- Free condition: slot_free = !out_valid | out_ready. This is combinational from out_ready and allows full throughput of 1 op/cycle.
- Arbitration (combinational): starting at the RR pointer p, scan p, p+1, ..., NREQ-1, 0, ..., p-1. The first i with req_valid[i]=1 is the grant g.
- req_ready[g]=1 only when slot_free=1 and at least one valid exists. All other req_ready bits are 0, so req_ready is at most one-hot.
- Accept: occurs when req_valid[g] & req_ready[g]. On that edge:
  - out_sum <= zero-extended a_g+b_g+c_g.
  - out_id <= g.
  - out_valid <= 1.
  - p <= (g+1) mod NREQ.
- Latency: exactly 1 cycle from accept edge to out_valid=1.
- No accept while slot_free=1: out_valid <= 0, out_sum and out_id hold their values, p holds.
- Backpressure: out_valid=1 & out_ready=0 holds out_sum, out_id and out_valid stable, and drives all req_ready=0.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and the new result replaces the old one. No bubble.
- op_count increments on every out_valid & out_ready edge and wraps from 0xFFFF to 0x0000.
- Arithmetic: maximum result is 3*(2^W-1) (765 for W=8). Bit W+2 of out_sum is always 0 and is kept for compatibility with the 11-bit datapath. No overflow or truncation is possible.
- Requesters must hold valid and operands stable until ready. A requester that drops valid before grant simply loses arbitration; this is not an error.
- Fairness: a continuously asserted requester is granted within NREQ accepts.
- Reset asserted mid-operation discards the held result with no output handshake, and op_count returns to 0.

Test Plan:
1. Reset, then requester 0 sends a=255, b=255, c=255 with out_ready=1. Required: req_ready[0]=1 that cycle; next cycle out_valid=1, out_sum=765 (0x2FD), out_id=0; op_count=1 after the drain.
2. All 4 requesters valid continuously, out_ready=1. Required: grants in order 0,1,2,3,0,1 on consecutive cycles, out_valid=1 on every cycle after the first, no bubbles.
3. Only requesters 1 and 3 valid with p=2. Required: grant order 3,1,3,1.
4. Result held with out_ready=0 for 5 cycles while requester 2 is valid. Required: out_sum and out_id stable, req_ready=0 throughout. Raise out_ready: in the same cycle req_ready[2]=1, and the new result appears the next cycle.
5. Operands a=0, b=0, c=0. Required: out_sum=0. Operands a=128, b=128, c=1. Required: out_sum=257.
6. Assert rst_n=0 while out_valid=1 and op_count=3. Required: next cycle out_valid=0, op_count=0, p=0, and no accept occurs during reset.

Source files
------------

// File: rtl/rca_sum_arbiter.sv
// Round-robin shared 3-operand adder: NREQ valid/ready requesters feed one
// carry-save + ripple-carry summation stage into a tagged output register.
module rca_sum_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*W-1:0]   req_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+2:0]        out_sum,
    output logic [IDW-1:0]      out_id,
    output logic [15:0]         op_count
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] ptr_next;
    logic           any_valid;
    logic           slot_free;
    logic           accept;

    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   c_sel;
    logic [W-1:0]   csa_s;
    logic [W-1:0]   csa_c;
    logic [W+1:0]   rca_sum;
    logic [W+2:0]   sum_ext;

    assign slot_free = !out_valid || out_ready;

    // Rotating priority scan starting at rr_ptr, wrapping at NREQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    // rst_n gates the handshake so nothing is accepted while in reset.
    assign accept = rst_n && slot_free && any_valid;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
                c_sel = req_c[i*W +: W];
            end
        end
    end

    // 3:2 compression, then a single ripple-carry add of sum and shifted carry.
    assign csa_s = a_sel ^ b_sel ^ c_sel;
    assign csa_c = (a_sel & b_sel) | (a_sel & c_sel) | (b_sel & c_sel);

    always_comb begin
        logic [W+1:0] x;
        logic [W+1:0] y;
        logic         carry;
        x       = {2'b00, csa_s};
        y       = {1'b0, csa_c, 1'b0};
        carry   = 1'b0;
        rca_sum = '0;
        // NOTE: blocking assignments here model the carry rippling bit by bit
        // within one evaluation; registers below use non-blocking only.
        for (int i = 0; i < W + 2; i++) begin
            rca_sum[i] = x[i] ^ y[i] ^ carry;
            carry      = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
        end
    end

    // Top bit is structurally zero: 3*(2^W-1) fits in W+2 bits.
    assign sum_ext = {1'b0, rca_sum};

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it only takes effect on a clock edge.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            op_count  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_sum   <= sum_ext;
                out_id    <= grant;
                out_valid <= 1'b1;
                rr_ptr    <= ptr_next;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rca_sum_arbiter.sv
// Directed bench for rca_sum_arbiter: hand-computed grants, sums, tags and
// drain counts across reset, round-robin, backpressure and mid-run reset.
module tb_rca_sum_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ*W-1:0]   req_c;
    logic                out_valid;
    logic                out_ready;
    logic [W+2:0]        out_sum;
    logic [IDW-1:0]      out_id;
    logic [15:0]         op_count;

    int checks = 0;
    int errors = 0;

    rca_sum_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c[i*W +: W] = c;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        out_ready = 1'b1;

        // Reset with every requester valid: no ready, cleared outputs.
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        rst_n     = 1'b1;
        req_valid = '0;

        // Maximum operands from requester 0.
        set_ops(0, 8'd255, 8'd255, 8'd255);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'd765);
        check("t1_id", 32'(out_id), 32'd0);
        check("t1_count_pre", 32'(op_count), 32'd0);
        step();
        check("t1_count", 32'(op_count), 32'd1);
        check("t1_idle_valid", 32'(out_valid), 32'd0);

        // All four valid: strict rotation 0,1,2,3,0,1 with no bubbles.
        reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 8'(10 + i), 8'd20, 8'd30);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            g = k % 4;
            #1;
            check("t2_ready", 32'(req_ready), 32'(1 << g));
            step();
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_id", 32'(out_id), 32'(g));
            check("t2_sum", 32'(out_sum), 32'(60 + g));
        end

        // Only 1 and 3 valid, pointer now at 2.
        req_valid = 4'b1010;
        check("t2_count", 32'(op_count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 3 : 1;
            #1;
            check("t3_ready", 32'(req_ready), 32'(1 << g));
            step();
            check("t3_id", 32'(out_id), 32'(g));
            check("t3_sum", 32'(out_sum), 32'(60 + g));
        end

        // Backpressure for 5 cycles with requester 2 waiting.
        out_ready = 1'b0;
        set_ops(2, 8'd100, 8'd50, 8'd7);
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_ready_hold", 32'(req_ready), 32'h0);
            step();
            check("t4_valid_hold", 32'(out_valid), 32'd1);
            check("t4_sum_hold", 32'(out_sum), 32'd61);
            check("t4_id_hold", 32'(out_id), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t4_ready_release", 32'(req_ready), 32'h4);
        step();
        check("t4_sum", 32'(out_sum), 32'd157);
        check("t4_id", 32'(out_id), 32'd2);
        check("t4_count", 32'(op_count), 32'd10);

        // Arithmetic corners through requester 0.
        set_ops(0, 8'd0, 8'd0, 8'd0);
        req_valid = 4'b0001;
        #1;
        check("t5_ready", 32'(req_ready), 32'h1);
        step();
        check("t5_sum_zero", 32'(out_sum), 32'd0);
        check("t5_id", 32'(out_id), 32'd0);
        set_ops(0, 8'd128, 8'd128, 8'd1);
        #1;
        step();
        req_valid = '0;
        check("t5_sum_257", 32'(out_sum), 32'd257);
        check("t5_count", 32'(op_count), 32'd12);

        // Mid-run reset with a held result and op_count=3.
        reset_dut();
        set_ops(0, 8'd1, 8'd2, 8'd3);
        req_valid = 4'b0001;
        repeat (4) step();
        check("t6_pre_count", 32'(op_count), 32'd3);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_sum", 32'(out_sum), 32'd6);
        req_valid = 4'hF;
        rst_n     = 1'b0;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        step();
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(op_count), 32'd0);
        check("t6_sum", 32'(out_sum), 32'd0);
        check("t6_id", 32'(out_id), 32'd0);
        rst_n = 1'b1;
        #1;
        check("t6_ptr_zero", 32'(req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
